// File: rtl/arith_resize_pipe.sv
// arith_resize_pipe: multi-lane integer width converter with an elastic
// valid/ready pipeline of DEPTH register stages.
//   clock, reset           rising-edge clock, async active-low reset
//   in_valid/in_ready      input handshake (in_ready is combinational)
//   in_data, in_mode       CH lanes of IN_W bits, 2-bit mode per lane
//                          (0 ZERO, 1 SIGN, 2 SAT_U, 3 SAT_S)
//   out_valid/out_ready    output handshake
//   out_data, out_sat      CH lanes of OUT_W bits, per-lane clamp flag
//   sat_sticky, sat_clear  per-lane sticky clamp flags, synchronous clear
module arith_resize_pipe #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic [CH*2-1:0]       in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_sat,
  output logic [CH-1:0]         sat_sticky,
  input  logic                  sat_clear
);

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_SIGN  = 2'd1;
  localparam logic [1:0] MODE_SAT_U = 2'd2;
  localparam logic [1:0] MODE_SAT_S = 2'd3;

  logic [CH*OUT_W-1:0] conv_data;
  logic [CH-1:0]       conv_sat;

  // Per-lane conversion, combinational on the input beat
  for (genvar i = 0; i < int'(CH); i++) begin : g_lane
    logic [IN_W-1:0]  x;
    logic [1:0]       m;
    logic [OUT_W-1:0] y;
    logic             s;

    assign x = in_data[i*IN_W +: IN_W];
    assign m = in_mode[2*i +: 2];

    if (OUT_W >= IN_W) begin : g_widen
      always_comb begin
        y = OUT_W'(x);
        s = 1'b0;
        if (m == MODE_SIGN || m == MODE_SAT_S) y = OUT_W'($signed(x));
      end
    end else begin : g_narrow
      localparam logic [OUT_W-1:0] MIN_NEG = OUT_W'(1) << (OUT_W - 1);
      localparam logic [OUT_W-1:0] MAX_POS = ~MIN_NEG;
      always_comb begin
        y = x[OUT_W-1:0];
        s = 1'b0;
        case (m)
          MODE_ZERO, MODE_SIGN: ;
          MODE_SAT_U: begin
            if (|x[IN_W-1:OUT_W]) begin
              y = '1;
              s = 1'b1;
            end
          end
          MODE_SAT_S: begin
            // Fits only if the dropped bits plus the new sign bit all agree
            if (!((&x[IN_W-1:OUT_W-1]) || !(|x[IN_W-1:OUT_W-1]))) begin
              y = x[IN_W-1] ? MIN_NEG : MAX_POS;
              s = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    assign conv_data[i*OUT_W +: OUT_W] = y;
    assign conv_sat[i] = s;
  end

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   adv, load;
  logic [CH*OUT_W-1:0] data_q [DEPTH];
  logic [CH*OUT_W-1:0] data_d [DEPTH];
  logic [CH-1:0]       sat_q  [DEPTH];
  logic [CH-1:0]       sat_d  [DEPTH];
  logic [CH-1:0]       sticky_q, sticky_d;

  // Ready chain: resolve from the output stage back towards the input
  always_comb begin
    adv  = '0;
    load = '0;
    adv[DEPTH-1] = valid_q[DEPTH-1] & out_ready;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      load[k]  = valid_q[k-1] & (~valid_q[k] | adv[k]);
      adv[k-1] = load[k];
    end
    in_ready = ~valid_q[0] | adv[0];
    load[0]  = in_valid & in_ready;
  end

  // Next-state for stage registers and sticky flags
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      valid_d[k] = load[k] ? 1'b1 : (adv[k] ? 1'b0 : valid_q[k]);
      data_d[k]  = data_q[k];
      sat_d[k]   = sat_q[k];
    end
    if (load[0]) begin
      data_d[0] = conv_data;
      sat_d[0]  = conv_sat;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (load[k]) begin
        data_d[k] = data_q[k-1];
        sat_d[k]  = sat_q[k-1];
      end
    end
    // Set on output transfer takes priority over clear
    sticky_d = (sat_clear ? '0 : sticky_q) | (adv[DEPTH-1] ? sat_q[DEPTH-1] : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      sticky_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
        sat_q[k]  <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
        sat_q[k]  <= sat_d[k];
      end
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];
  assign out_sat    = sat_q[DEPTH-1];
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_arith_resize_pipe.sv
// Directed bench: widening instance (4->8) and narrowing instance (8->4),
// both CH=2, DEPTH=2, sharing clock and reset.
module tb_arith_resize_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_sat_clear;
  logic [7:0]  w_in_data;
  logic [3:0]  w_in_mode;
  logic [15:0] w_out_data;
  logic [1:0]  w_out_sat, w_sat_sticky;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_sat_clear;
  logic [15:0] n_in_data;
  logic [3:0]  n_in_mode;
  logic [7:0]  n_out_data;
  logic [1:0]  n_out_sat, n_sat_sticky;

  int checks = 0;
  int errors = 0;

  arith_resize_pipe #(.IN_W(4), .OUT_W(8), .CH(2), .DEPTH(2)) dut_w (
    .clock(clock), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_mode(w_in_mode),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_sat(w_out_sat),
    .sat_sticky(w_sat_sticky), .sat_clear(w_sat_clear)
  );

  arith_resize_pipe #(.IN_W(8), .OUT_W(4), .CH(2), .DEPTH(2)) dut_n (
    .clock(clock), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_mode(n_in_mode),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .out_sat(n_out_sat),
    .sat_sticky(n_sat_sticky), .sat_clear(n_sat_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One beat into the narrowing instance, checked DEPTH cycles later
  task automatic n_beat(input string tag, input logic [15:0] d, input logic [3:0] m,
                        input logic [7:0] ed, input logic [1:0] es);
    n_in_valid = 1'b1;
    n_in_data  = d;
    n_in_mode  = m;
    tick();
    n_in_valid = 1'b0;
    check({tag, "_lat"}, 32'(n_out_valid), 32'h0);
    tick();
    check({tag, "_v"}, 32'(n_out_valid), 32'h1);
    check({tag, "_d"}, 32'(n_out_data), 32'(ed));
    check({tag, "_s"}, 32'(n_out_sat), 32'(es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    reset = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_out_ready = 1'b1; w_sat_clear = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_in_mode = '0; n_out_ready = 1'b1; n_sat_clear = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_w_valid", 32'(w_out_valid), 32'h0);
    check("rst_w_data", 32'(w_out_data), 32'h0);
    check("rst_w_ready", 32'(w_in_ready), 32'h1);
    check("rst_n_valid", 32'(n_out_valid), 32'h0);
    check("rst_n_ready", 32'(n_in_ready), 32'h1);
    reset = 1'b1;
    tick();
    check("rst_w_sat", 32'(w_out_sat), 32'h0);
    check("rst_n_sticky", 32'(n_sat_sticky), 32'h0);

    // Widening: SIGN then ZERO
    w_in_valid = 1'b1; w_in_data = 8'h5A; w_in_mode = 4'b0101;
    tick();
    check("w_lat1", 32'(w_out_valid), 32'h0);
    w_in_data = 8'h5A; w_in_mode = 4'b0000;
    tick();
    w_in_valid = 1'b0;
    check("w_sign_v", 32'(w_out_valid), 32'h1);
    check("w_sign_d", 32'(w_out_data), 32'h05FA);
    check("w_sign_s", 32'(w_out_sat), 32'h0);
    tick();
    check("w_zero_v", 32'(w_out_valid), 32'h1);
    check("w_zero_d", 32'(w_out_data), 32'h050A);
    tick();
    check("w_empty_v", 32'(w_out_valid), 32'h0);
    check("w_empty_hold", 32'(w_out_data), 32'h050A);

    // Narrowing: signed saturate, unsigned saturate, truncation
    n_beat("n_sats_clamp", 16'h807F, 4'b1111, 8'h87, 2'b11);
    n_beat("n_sats_fit",   16'h05FE, 4'b1111, 8'h5E, 2'b00);
    n_beat("n_satu",       16'h0C1F, 4'b1010, 8'hCF, 2'b01);
    n_beat("n_trunc",      16'h801F, 4'b0100, 8'h0F, 2'b00);
    tick();
    check("n_sticky_acc", 32'(n_sat_sticky), 32'h3);

    // Sticky: clear, set on lane1, set-and-clear, clear alone
    n_sat_clear = 1'b1;
    tick();
    n_sat_clear = 1'b0;
    check("n_sticky_clr0", 32'(n_sat_sticky), 32'h0);
    n_beat("n_l1sat_a", 16'h8005, 4'b1111, 8'h85, 2'b10);
    check("n_sticky_pre", 32'(n_sat_sticky), 32'h0);
    tick();
    check("n_sticky_set", 32'(n_sat_sticky), 32'h2);
    n_beat("n_l1sat_b", 16'h8005, 4'b1111, 8'h85, 2'b10);
    n_sat_clear = 1'b1;
    tick();
    n_sat_clear = 1'b0;
    check("n_sticky_setwins", 32'(n_sat_sticky), 32'h2);
    n_sat_clear = 1'b1;
    tick();
    n_sat_clear = 1'b0;
    check("n_sticky_clr", 32'(n_sat_sticky), 32'h0);

    // Backpressure: 5 beats, out_ready low for cycles 3..6
    sent = 0;
    got = 0;
    for (int cyc = 1; cyc <= 30 && got < 5; cyc++) begin
      w_out_ready = !(cyc >= 3 && cyc <= 6);
      w_in_valid  = (sent < 5);
      w_in_data   = 8'(sent + 1);
      w_in_mode   = 4'b0000;
      #1;
      if (cyc == 4) begin
        check("bp_in_ready", 32'(w_in_ready), 32'h0);
        check("bp_hold_v", 32'(w_out_valid), 32'h1);
        check("bp_hold_d", 32'(w_out_data), 32'h0001);
      end
      if (cyc >= 7) check($sformatf("bp_nogap%0d", cyc), 32'(w_out_valid), 32'h1);
      if (w_in_valid && w_in_ready) sent++;
      if (w_out_valid && w_out_ready) begin
        check($sformatf("bp_out%0d", got), 32'(w_out_data), 32'(got + 1));
        got++;
      end
      tick();
    end
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd5);

    // Reset with two beats in flight
    w_out_ready = 1'b0;
    w_in_valid = 1'b1; w_in_data = 8'h77;
    tick();
    w_in_data = 8'h66;
    tick();
    w_in_valid = 1'b0;
    check("mrst_pre_v", 32'(w_out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_async_v", 32'(w_out_valid), 32'h0);
    check("mrst_async_d", 32'(w_out_data), 32'h0);
    tick();
    reset = 1'b1;
    w_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mrst_nostale%0d", c), 32'(w_out_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_resize_pipe.md
Name: arith_resize_pipe

Overview:
Multi-channel, pipelined width converter for integer datapaths; successor to the single-mode extender.
- Each of CH lanes converts an IN_W-bit value to OUT_W bits under a per-lane mode: zero-fill, sign-fill, unsigned-saturate or signed-saturate.
- Supports both widening (OUT_W >= IN_W) and narrowing (OUT_W < IN_W).
- Carried through DEPTH registered stages with a valid/ready elastic handshake; sits between register-read and execute.
- Reports per-lane saturation, plus sticky flags.

Parameters:
IN_W, 4, input lane width (>=1)
OUT_W, 8, output lane width (>=1; may be < IN_W)
CH, 2, number of lanes (>=1)
DEPTH, 2, pipeline register stages (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  pipeline can accept beat this cycle
in_data  in  CH*IN_W  lane i at [i*IN_W +: IN_W]
in_mode  in  CH*2  lane i mode at [2i +: 2]: 0 ZERO, 1 SIGN, 2 SAT_U, 3 SAT_S
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_data  out  CH*OUT_W  lane i at [i*OUT_W +: OUT_W]
out_sat  out  CH  lane i result was clamped (qualified by out_valid)
sat_sticky  out  CH  lane i has clamped since last clear
sat_clear  in  1  synchronous clear of sat_sticky

Behaviour:
- Reset (reset=0, asynchronous): all stage valids = 0, stage data/sat = 0, sat_sticky = 0. Hence out_valid=0, out_data=0, out_sat=0 until the first beat emerges. Reset mid-flight discards all in-flight beats.
- Conversion is combinational on input and registered into stage 1. Stages 2..DEPTH are pure delay. Mode is sampled with its data in the same handshake.
- Widening (OUT_W >= IN_W):
  - ZERO and SAT_U zero-fill the upper bits.
  - SIGN and SAT_S replicate in[IN_W-1].
  - out_sat = 0.
- Narrowing (OUT_W < IN_W):
  - ZERO and SIGN: truncate to the low OUT_W bits; out_sat = 0.
  - SAT_U: treat input as unsigned. If in > 2^OUT_W-1, output all-ones and out_sat=1; else low bits.
  - SAT_S: treat input as signed. If in > 2^(OUT_W-1)-1, output 0 followed by ones (max positive). If in < -2^(OUT_W-1), output 1 followed by zeros (min negative). out_sat=1 in either clamp case; else low bits.
- Handshake, per stage k: stage k loads when its upstream is valid and (stage k empty, or stage k advancing this cycle).
  - Last stage advances when out_ready=1.
  - in_ready = stage 1 empty, or stage 1 advancing. The combinational ready chain is permitted.
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
- Latency: exactly DEPTH cycles from input transfer to out_valid when there are no stalls. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sat hold stable. Bubbles upstream still compress. No beat is dropped or duplicated, and order is preserved.
- in_valid with in_ready=0: no transfer; the source must hold data.
- sat_sticky[i] sets on output transfer with out_sat[i]=1.
  - sat_clear=1 clears it next edge.
  - Simultaneous set and clear: set wins (flag = 1).
- When DEPTH pipeline is full and out_ready=0, in_ready=0.
- When the pipeline is empty, out_valid=0; out_data holds its last value (0 after reset).

Test Plan:
- Widen (IN_W=4, OUT_W=8, CH=2, DEPTH=2), reset pulsed low then released, out_ready=1:
  - Beat lane0=4'hA SIGN, lane1=4'h5 SIGN -> 2 cycles later out_valid=1, out_data lane0=8'hFA, lane1=8'h05, out_sat=0.
  - Next beat 4'hA ZERO -> 8'h0A.
- Narrow signed (IN_W=8, OUT_W=4), SAT_S:
  - 8'h7F -> 4'h7, sat=1.
  - 8'h80 -> 4'h8, sat=1.
  - 8'hFE -> 4'hE, sat=0.
  - 8'h05 -> 4'h5, sat=0.
- Narrow unsigned/truncate (IN_W=8, OUT_W=4):
  - SAT_U 8'h1F -> 4'hF, sat=1.
  - SAT_U 8'h0C -> 4'hC, sat=0.
  - ZERO 8'h1F -> 4'hF, sat=0.
  - SIGN 8'h80 -> 4'h0, sat=0.
- Backpressure, DEPTH=2: stream 5 beats (values 1..5) with out_ready=0 for cycles 3-6.
  - in_ready falls after 2 beats are held.
  - out_data stays 1 while stalled.
  - After release, outputs are 1,2,3,4,5 in order with no gaps or duplicates.
- Sticky/reset:
  - One saturating beat on lane1 -> sat_sticky=2'b10.
  - sat_clear together with a new lane1 saturation -> stays 2'b10.
  - sat_clear alone -> 2'b00.
  - Assert reset with 2 beats in flight -> out_valid=0 and out_data=0 immediately (asynchronously), with no stale beats after release.
